// File: rtl/vec_fp_add_seq_if.sv
// Bundle between the vector execute stage, the sequencer and the scalar adder_fp unit.
// The slave modport is the sequencer's view; master is the environment's (stage + adder).
interface vec_fp_add_seq_if #(
    parameter int LANES = 4,
    parameter int W     = 32
);
    logic               start;
    logic               op;
    logic [LANES*W-1:0] va;
    logic [LANES*W-1:0] vb;
    logic [LANES*W-1:0] vy;
    logic               busy;
    logic               done;
    logic               err;
    logic               fp_start;
    logic               fp_op;
    logic [W-1:0]       fp_a;
    logic [W-1:0]       fp_b;
    logic               fp_ready;
    logic [W-1:0]       fp_y;

    modport master (
        output start, op, va, vb, fp_ready, fp_y,
        input  vy, busy, done, err, fp_start, fp_op, fp_a, fp_b
    );

    modport slave (
        input  start, op, va, vb, fp_ready, fp_y,
        output vy, busy, done, err, fp_start, fp_op, fp_a, fp_b
    );
endinterface

// File: rtl/vec_fp_add_seq.sv
// Feeds a LANES-wide FP add/sub through the single scalar adder_fp, one lane per handshake.
// Optional per-lane watchdog enabled by defining VSEQ_TIMEOUT_EN.
module vec_fp_add_seq #(
    parameter int LANES   = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 64
) (
    input logic             clk,
    input logic             rst,
    vec_fp_add_seq_if.slave bus
);
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int VW = LANES * W;

    if (LANES < 1 || LANES > 16 || W != 32 || TIMEOUT < 1) begin : g_param_check
        $error("vec_fp_add_seq: unsupported LANES/W/TIMEOUT");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state;
    logic [VW-1:0]   va_q;
    logic [VW-1:0]   vb_q;
    logic [VW-1:0]   vy_q;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   nxt_idx;
    logic            last_lane;
    logic            busy_q;
    logic            done_q;
    logic            fp_start_q;
    logic            fp_op_q;
    logic [W-1:0]    fp_a_q;
    logic [W-1:0]    fp_b_q;

`ifdef VSEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tcnt;
    logic          err_q;
`endif

    assign nxt_idx   = idx + 1'b1;
    assign last_lane = (idx == IW'(LANES - 1));

    // ready is only looked at in WAIT, so a ready left high from the previous
    // lane is skipped over during the ISSUE cycle of the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            va_q       <= '0;
            vb_q       <= '0;
            vy_q       <= '0;
            idx        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fp_start_q <= 1'b0;
            fp_op_q    <= 1'b0;
            fp_a_q     <= '0;
            fp_b_q     <= '0;
`ifdef VSEQ_TIMEOUT_EN
            tcnt       <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            done_q     <= 1'b0;
            fp_start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        va_q       <= bus.va;
                        vb_q       <= bus.vb;
                        fp_op_q    <= bus.op;
                        idx        <= '0;
                        fp_a_q     <= bus.va[W-1:0];
                        fp_b_q     <= bus.vb[W-1:0];
                        fp_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= ISSUE;
`ifdef VSEQ_TIMEOUT_EN
                        err_q      <= 1'b0;
`endif
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef VSEQ_TIMEOUT_EN
                    tcnt  <= '0;
`endif
                end
                WAIT: begin
                    if (bus.fp_ready) begin
                        vy_q[int'(idx)*W +: W] <= bus.fp_y;
                        if (last_lane) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            idx        <= nxt_idx;
                            fp_a_q     <= va_q[int'(nxt_idx)*W +: W];
                            fp_b_q     <= vb_q[int'(nxt_idx)*W +: W];
                            fp_start_q <= 1'b1;
                            state      <= ISSUE;
                        end
                    end
`ifdef VSEQ_TIMEOUT_EN
                    else if (tcnt == CW'(TIMEOUT - 1)) begin
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.vy       = vy_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.fp_start = fp_start_q;
    assign bus.fp_op    = fp_op_q;
    assign bus.fp_a     = fp_a_q;
    assign bus.fp_b     = fp_b_q;
`ifdef VSEQ_TIMEOUT_EN
    assign bus.err      = err_q;
`else
    assign bus.err      = 1'b0;
`endif
endmodule

// File: tb/tb_vec_fp_add_seq.sv
// Bench for vec_fp_add_seq: latency-3 adder stub with a real-arithmetic FP model,
// queue scoreboards for issued lanes and completed vectors, table plus corner sequences.
module tb_vec_fp_add_seq;
    localparam int LANES     = 4;
    localparam int W         = 32;
    localparam int VW        = LANES * W;
    localparam int L         = 3;
    localparam int TMO       = 8;
    localparam int OP_CYCLES = LANES * (L + 1) + 1;

    typedef struct {
        logic          op;
        logic [VW-1:0] va;
        logic [VW-1:0] vb;
        logic [VW-1:0] exp_vy;
    } vec_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op;
    } issue_t;

    typedef struct {
        logic [VW-1:0] vy;
        logic          err;
    } result_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vec_fp_add_seq_if #(.LANES(LANES), .W(W)) bus ();

    vec_fp_add_seq #(.LANES(LANES), .W(W), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int done_cnt   = 0;
    int starts     = 0;
    int hold_len   = 1;
    int pend       = 0;
    int hold       = 0;
    logic [W-1:0]  stall_a = 32'hFFFF_FFFF;
    logic [VW-1:0] last_vy = '0;
    issue_t  fpq[$];
    result_t doneq[$];
    vec_t    tbl[4];

    task automatic check_output(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic real sp2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:0] == 31'd0) return 0.0;
        d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [30:0] mag;
        if (r == 0.0) return 32'h0;
        d   = $realtobits(r);
        mag = {8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
        if (d[28] && (d[27:0] != 28'd0 || d[29])) mag = mag + 31'd1;
        return {d[63], mag};
    endfunction

    function automatic logic [31:0] fp_model(input logic op, input logic [31:0] a, input logic [31:0] b);
        return r2sp(op ? sp2r(a) - sp2r(b) : sp2r(a) + sp2r(b));
    endfunction

    function automatic logic [VW-1:0] pack4(input logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    // adder stub: ready L cycles after sampling fp_start, held hold_len cycles,
    // dropped by the next fp_start; an operand equal to stall_a never completes
    always @(posedge clk) begin
        if (rst) begin
            bus.fp_ready <= 1'b0;
            bus.fp_y     <= '0;
            pend = 0;
            hold = 0;
        end else if (bus.fp_start) begin
            bus.fp_ready <= 1'b0;
            hold = 0;
            pend = (bus.fp_a == stall_a) ? 0 : L - 1;
        end else if (pend > 1) begin
            pend--;
        end else if (pend == 1) begin
            pend = 0;
            bus.fp_ready <= 1'b1;
            bus.fp_y     <= fp_model(bus.fp_op, bus.fp_a, bus.fp_b);
            hold = hold_len - 1;
        end else if (hold > 0) begin
            hold--;
        end else begin
            bus.fp_ready <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.fp_start) begin
            issue_t e;
            starts++;
            if (fpq.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL fp_issue: got unexpected issue of a=%h, expected none", bus.fp_a);
            end else begin
                e = fpq.pop_front();
                check_output("fp_a", VW'(bus.fp_a), VW'(e.a));
                check_output("fp_b", VW'(bus.fp_b), VW'(e.b));
                check_int("fp_op", int'(bus.fp_op), int'(e.op));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            result_t e;
            done_cnt++;
            if (doneq.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL done_pulse: got unexpected done, expected none");
            end else begin
                e = doneq.pop_front();
                check_output("vy", bus.vy, e.vy);
                check_int("err_at_done", int'(bus.err), int'(e.err));
            end
        end
    end

    task automatic apply_stimulus(input vec_t v, input int hold_cycles, input int restart_cyc,
                                  input int exp_done_cyc, input int exp_starts,
                                  input logic exp_err, input logic [VW-1:0] exp_vy);
        int d0 = done_cnt;
        int s0 = starts;
        int done_k = 0;
        int busy_bad = 0;
        hold_len = hold_cycles;
        @(negedge clk);
        for (int i = 0; i < exp_starts; i++)
            fpq.push_back('{v.va[i*W +: W], v.vb[i*W +: W], v.op});
        doneq.push_back('{exp_vy, exp_err});
        bus.op    = v.op;
        bus.va    = v.va;
        bus.vb    = v.vb;
        bus.start = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (restart_cyc > 0 && k == restart_cyc) begin
                bus.start = 1'b1;
                bus.op    = ~v.op;
                bus.va    = ~v.va;
                bus.vb    = v.va;
            end else if (restart_cyc > 0 && k == restart_cyc + 1) begin
                bus.start = 1'b0;
            end
            if (exp_done_cyc > 0 && bus.busy !== (k <= exp_done_cyc)) busy_bad++;
            if (bus.done && done_k == 0) done_k = k;
            if (done_k > 0 && k == done_k + 1) check_int("err_hold", int'(bus.err), int'(exp_err));
            if (done_k > 0 && k >= done_k + 3) break;
        end
        if (done_k == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL done_wait: got no done within 300 cycles, expected one");
            doneq.delete();
        end
        if (exp_done_cyc > 0) begin
            check_int("done_cycle", done_k, exp_done_cyc);
            check_int("busy_window_errors", busy_bad, 0);
        end
        check_int("done_count", done_cnt - d0, 1);
        check_int("fp_start_count", starts - s0, exp_starts);
        check_int("issue_queue_left", fpq.size(), 0);
        fpq.delete();
        last_vy = exp_vy;
    endtask

    task automatic reset_mid_op(input vec_t v, input int rst_cyc);
        int d0 = done_cnt;
        hold_len = 1;
        @(negedge clk);
        for (int i = 0; i < LANES; i++)
            fpq.push_back('{v.va[i*W +: W], v.vb[i*W +: W], v.op});
        bus.op    = v.op;
        bus.va    = v.va;
        bus.vb    = v.vb;
        bus.start = 1'b1;
        for (int k = 1; k <= rst_cyc; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check_output("rst_vy", bus.vy, '0);
        check_int("rst_ctrl", int'({bus.busy, bus.done, bus.err, bus.fp_start, bus.fp_op}), 0);
        check_output("rst_fp_a", VW'(bus.fp_a), '0);
        check_output("rst_fp_b", VW'(bus.fp_b), '0);
        rst = 1'b0;
        fpq.delete();
        repeat (30) @(negedge clk);
        check_int("done_after_abort", done_cnt - d0, 0);
        last_vy = '0;
    endtask

    initial begin
        tbl[0] = '{1'b0,
                   pack4(32'h400CCCCD, 32'h400CCCCD, 32'h400CCCCD, 32'h400CCCCD),
                   pack4(32'h400CCCCD, 32'h400CCCCD, 32'h400CCCCD, 32'h400CCCCD),
                   pack4(32'h408CCCCD, 32'h408CCCCD, 32'h408CCCCD, 32'h408CCCCD)};
        tbl[1] = '{1'b0,
                   pack4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000),
                   pack4(32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000),
                   pack4(32'h3FC00000, 32'h40200000, 32'h40600000, 32'h40900000)};
        tbl[2] = '{1'b1,
                   pack4(32'h41200000, 32'h3F800000, 32'h40C00000, 32'h41000000),
                   pack4(32'hC0200000, 32'h3E800000, 32'h40C00000, 32'h40000000),
                   pack4(32'h41480000, 32'h3F400000, 32'h00000000, 32'h40C00000)};
        tbl[3] = '{1'b0,
                   pack4(32'hBFC00000, 32'h42C80000, 32'h3F800000, 32'h40400000),
                   pack4(32'h3F800000, 32'h41E00000, 32'h33800000, 32'hBF000000),
                   pack4(32'hBF000000, 32'h43000000, 32'h3F800000, 32'h40200000)};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.va    = '0;
        bus.vb    = '0;
        repeat (3) @(negedge clk);
        check_output("reset_vy", bus.vy, '0);
        check_int("reset_ctrl", int'({bus.busy, bus.done, bus.err, bus.fp_start, bus.fp_op}), 0);
        check_output("reset_fp_a", VW'(bus.fp_a), '0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++)
            apply_stimulus(tbl[i], 1, 0, OP_CYCLES, LANES, 1'b0, tbl[i].exp_vy);

        // second start in cycle 5 must not disturb the operation in flight
        apply_stimulus(tbl[0], 1, 5, OP_CYCLES, LANES, 1'b0, tbl[0].exp_vy);

        // ready held 3 cycles overlaps the next ISSUE
        apply_stimulus(tbl[2], 3, 0, OP_CYCLES, LANES, 1'b0, tbl[2].exp_vy);

        reset_mid_op(tbl[3], 8);
        apply_stimulus(tbl[1], 1, 0, OP_CYCLES, LANES, 1'b0, tbl[1].exp_vy);

`ifdef VSEQ_TIMEOUT_EN
        stall_a = 32'h3F800000;
        apply_stimulus(tbl[3], 1, 0, 0, 3, 1'b1, {last_vy[VW-1:2*W], tbl[3].exp_vy[2*W-1:0]});
        stall_a = 32'hFFFF_FFFF;
        apply_stimulus(tbl[0], 1, 0, OP_CYCLES, LANES, 1'b0, tbl[0].exp_vy);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/vec_fp_add_seq.md
# vec_fp_add_seq

Vector sequencer that sits directly upstream of the ALU's `adder_fp` unit and also consumes its results. On a one-cycle `start`, it latches two LANES-element vectors of IEEE-754 single-precision values. It then issues one element pair at a time to `adder_fp` through its start/ready handshake and collects each `Y` into a result vector. `done` pulses once all lanes are written back. This lets the ASIP's vector execute stage use the existing scalar FP adder without a per-lane adder.

## Interface
Parameters:
- `LANES`, 4: number of vector elements; legal range 1–16.
- `W`, 32: element width in bits; fixed to 32 for `adder_fp`.
- `TIMEOUT`, 64: watchdog limit in cycles per element; used only when `VSEQ_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `op`  in  1  0 = add, 1 = subtract; forwarded to `adder_fp`.
- `va`  in  LANES*W  operand A vector; lane i is at `[i*W +: W]`.
- `vb`  in  LANES*W  operand B vector; same packing as `va`.
- `vy`  out  LANES*W  result vector; holds its value until the next accepted `start`.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  one-cycle pulse when all lanes are written.
- `err`  out  1  timeout flag; constant 0 without `VSEQ_TIMEOUT_EN`.
- `fp_start`  out  1  drives `adder_fp.start`.
- `fp_op`  out  1  drives `adder_fp.op`.
- `fp_a`  out  W  drives `adder_fp.A`.
- `fp_b`  out  W  drives `adder_fp.B`.
- `fp_ready`  in  1  from `adder_fp.ready`.
- `fp_y`  in  W  from `adder_fp.Y`.

## Operation
- States and transitions:
  - IDLE: go to ISSUE on `start`; otherwise stay.
  - ISSUE: always go to WAIT.
  - WAIT: on `fp_ready`, go to ISSUE if `idx < LANES-1`, else to DONE.
  - DONE: always go to IDLE.
- Accepting `start` in IDLE:
  - latch `va`, `vb` and `op`;
  - set `idx` = 0;
  - clear `err`.
- ISSUE:
  - `fp_start` = 1 for exactly this cycle;
  - `fp_a` / `fp_b` = latched lane `idx`.
- WAIT:
  - `fp_start` = 0;
  - `fp_a`, `fp_b` and `fp_op` stay stable on lane `idx`;
  - on the first cycle with `fp_ready` = 1, write `fp_y` into `vy` lane `idx` and increment `idx`.
- `fp_ready` during the ISSUE cycle is ignored, to reject stale ready from the previous operation.
- DONE: `done` = 1 for one cycle.
- `vy` is replaced lane by lane during an operation. Lanes not yet reached keep their previous values.
- `start` while `busy` is ignored; the operands in flight are unaffected.
- `idx` is a ceil(log2(LANES))-bit counter; it never wraps within an operation.
- With LANES = 1 the sequence is ISSUE → WAIT → DONE.

## Timing
- Reset values (also the result of reset asserted mid-operation):
  - state = IDLE;
  - `busy`, `done`, `err`, `fp_start` = 0;
  - `fp_a`, `fp_b`, `fp_op`, `vy`, `idx` = 0.
  - An aborted operation produces no `done`.
- Cycle numbering: `start` is sampled at edge 0.
  - ISSUE for lane 0 is cycle 1.
  - The adder raises `fp_ready` L ≥ 1 cycles after it samples `fp_start`.
- Each lane costs L+1 cycles. `done` is high in cycle LANES*(L+1)+1.
- `busy` is high in cycles 1 through LANES*(L+1)+1.
- The earliest next `start` is sampled in the cycle after `done`.
- `fp_ready` held high across multiple cycles is captured once per lane; the next ISSUE ignores it.

## Configuration
- Macro: `VSEQ_TIMEOUT_EN`.
- Defined:
  - a per-lane counter is cleared in ISSUE and counts in WAIT;
  - if it reaches `TIMEOUT` without `fp_ready`, go to DONE;
  - `err` = 1 and holds until the next accepted `start` or `rst`;
  - the stuck lane and all higher lanes keep their prior `vy` values.
- Undefined:
  - no counter exists;
  - WAIT waits indefinitely;
  - `err` is tied to 0.

## Test plan
Use a stub adder with fixed latency L = 3 that returns A+B. Where an exact float result matters, use a behavioural model.
- Basic add: LANES = 4, op = 0, all lanes A = B = 0x400CCCCD (2.2) → `vy` = 4 × 0x408CCCCD (4.4); `done` in cycle 17; `busy` high in cycles 1–17.
- Lane ordering: `va` lane i = 0x3F800000 × i-pattern distinct per lane → the `fp_a` sequence matches lanes 0,1,2,3 in that order, with exactly one `fp_start` pulse per lane.
- Ignored start: pulse `start` again in cycle 5 with different operands → the result is unchanged and only one `done` is produced.
- Reset mid-operation: assert `rst` in cycle 8 → the next cycle shows all outputs 0 and state IDLE; no `done` pulse follows; a new `start` then completes normally.
- Held ready: stub keeps `fp_ready` high for 3 cycles → each lane is captured once and `vy` is correct.
- Timeout (`VSEQ_TIMEOUT_EN`, TIMEOUT = 8): stub never asserts ready on lane 2 → `done` and `err` = 1 in the same cycle; lanes 0–1 updated; lanes 2–3 unchanged.
